// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory/writeback stage: access sizes, funct3 codes, FSM states.
package mem_access_stage_pkg;

  localparam logic [1:0] SzB = 2'b00;
  localparam logic [1:0] SzH = 2'b01;
  localparam logic [1:0] SzW = 2'b10;

  // funct3[UnsBit] selects zero-extension on loads
  localparam int unsigned UnsBit = 2;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic {StIdle, StBusy} state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata >> {off, 3'b000};
    be       = 4'b0000;
    wdata    = '0;
    ld_data  = shifted;
    misalign = 1'b0;
    case (size)
      SzB: begin
        be      = 4'b0001 << off;
        wdata   = {4{wd[7:0]}};
        ld_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SzH: begin
        be       = 4'b0011 << off;
        wdata    = {2{wd[15:0]}};
        ld_data  = {{16{~uns & shifted[15]}}, shifted[15:0]};
        misalign = off[0];
      end
      SzW: begin
        be       = 4'hF;
        wdata    = wd;
        misalign = |off;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory/writeback stage: single-outstanding dmem req/ack, load extension, one wb beat per retire.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_store,
  input  logic        ex_load,
  input  logic        ex_we_reg,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wd_mem,
  input  logic [31:0] ex_wd_reg,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wd,
  output logic        misalign,
  output logic        timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_load_q;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic            uns_q;
  logic [4:0]      rd_q;

  logic        busy, accept, timed_out;
  logic [1:0]  al_size, al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld_data;
  logic        al_misalign;

  assign busy      = (state_q == StBusy);
  assign ex_ready  = (state_q == StIdle) && !RST;
  assign accept    = ex_valid && ex_ready;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntLast);

  // In IDLE the aligner decodes the incoming beat; in BUSY it extracts load data from the latch.
  assign al_size = busy ? size_q : ex_funct3[1:0];
  assign al_uns  = busy ? uns_q  : ex_funct3[UnsBit];
  assign al_off  = busy ? off_q  : ex_addr[1:0];

  lsu_lane_align u_align (
    .size     (al_size),
    .uns      (al_uns),
    .off      (al_off),
    .wd       (ex_wd_mem),
    .rdata    (dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld_data),
    .misalign (al_misalign)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_wd       <= '0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_wd       <= '0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!(ex_store || ex_load)) begin
              wb_valid <= 1'b1;
              wb_we    <= ex_we_reg && (ex_rd != '0);
              wb_rd    <= ex_rd;
              wb_wd    <= ex_wd_reg;
            end else if (al_misalign) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              misalign <= 1'b1;
            end else begin
              state_q    <= StBusy;
              cnt_q      <= '0;
              is_load_q  <= !ex_store;
              size_q     <= ex_funct3[1:0];
              uns_q      <= ex_funct3[UnsBit];
              off_q      <= ex_addr[1:0];
              rd_q       <= ex_rd;
              dmem_req   <= 1'b1;
              dmem_we    <= ex_store;
              dmem_addr  <= {ex_addr[31:2], 2'b00};
              dmem_be    <= al_be;
              dmem_wdata <= al_wdata;
            end
          end
        end
        StBusy: begin
          // An ack in the timeout cycle takes priority and retires normally.
          if (dmem_ack || timed_out) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b1;
            wb_rd      <= rd_q;
            if (dmem_ack) begin
              wb_we <= is_load_q && (rd_q != '0);
              wb_wd <= is_load_q ? al_ld_data : '0;
            end else begin
              timeout_err <= 1'b1;
            end
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scripted bench for mem_access_stage with a writeback scoreboard checked on the falling edge.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int unsigned Timeout = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_store = 1'b0, ex_load = 1'b0, ex_we_reg = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_wd_mem = '0, ex_wd_reg = '0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_we, misalign, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wd;
    logic        mis;
    logic        tmo;
    logic        chk_rd;
  } wb_exp_t;

  wb_exp_t sb[$];
  int      n_checks = 0;
  int      n_errors = 0;
  bit      mon_en = 1'b0;

  always #5 CLK = ~CLK;

  mem_access_stage #(.TIMEOUT(Timeout)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_store    (ex_store),
    .ex_load     (ex_load),
    .ex_we_reg   (ex_we_reg),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wd_mem   (ex_wd_mem),
    .ex_wd_reg   (ex_wd_reg),
    .ex_rd       (ex_rd),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_wd       (wb_wd),
    .misalign    (misalign),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic we, input logic [31:0] wd,
                         input logic mis, input logic tmo, input logic chk_rd);
    wb_exp_t e;
    e.rd = rd; e.we = we; e.wd = wd; e.mis = mis; e.tmo = tmo; e.chk_rd = chk_rd;
    sb.push_back(e);
  endtask

  // Drive one beat for exactly one edge, then scramble the fields to prove they are sampled once.
  task automatic issue(input logic st, input logic ld, input logic we_reg, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd_mem,
                       input logic [31:0] wd_reg, input logic [4:0] rd);
    chk("ex_ready_pre", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_store = st; ex_load = ld; ex_we_reg = we_reg; ex_funct3 = f3;
    ex_addr = addr; ex_wd_mem = wd_mem; ex_wd_reg = wd_reg; ex_rd = rd;
    tick();
    ex_valid = 1'b0;
    ex_store = 1'($urandom); ex_load = 1'($urandom); ex_we_reg = 1'($urandom);
    ex_funct3 = 3'($urandom); ex_addr = $urandom; ex_wd_mem = $urandom;
    ex_wd_reg = $urandom; ex_rd = 5'($urandom);
  endtask

  // lat = number of BUSY cycles including the ack cycle.
  task automatic mem_txn(input logic st, input logic both, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input int lat, input logic [31:0] rdata, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] ld_exp);
    issue(st, !st || both, 1'b1, f3, addr, wd, 32'h0, rd);
    for (int i = 0; i < lat; i++) begin
      chk("req_held", dmem_req, 1'b1);
      chk("req_we", dmem_we, st);
      chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("req_be", dmem_be, be);
      chk("req_wdata", dmem_wdata, wdata);
      chk("busy_not_ready", ex_ready, 1'b0);
      if (i == lat - 1) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        if (st) push_wb(rd, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        else    push_wb(rd, rd != 5'd0, ld_exp, 1'b0, 1'b0, 1'b1);
      end else begin
        dmem_rdata = $urandom;
      end
      tick();
    end
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    chk("req_dropped", dmem_req, 1'b0);
    chk("ready_after_ack", ex_ready, 1'b1);
  endtask

  task automatic mis_txn(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    push_wb(rd, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b1, f3, addr, 32'h0, 32'h0, rd);
    chk("mis_no_req", dmem_req, 1'b0);
    chk("mis_ready", ex_ready, 1'b1);
    tick();
    chk("mis_no_req2", dmem_req, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'(|{dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   wb_valid, wb_we, wb_rd, wb_wd, misalign, timeout_err}), 32'h0);
  endtask

  always @(negedge CLK) begin
    wb_exp_t e;
    if (mon_en) begin
      if (wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("wb_we", wb_we, e.we);
          chk("wb_wd", wb_wd, e.wd);
          chk("wb_misalign", misalign, e.mis);
          chk("wb_timeout", timeout_err, e.tmo);
          if (e.chk_rd) chk("wb_rd", wb_rd, e.rd);
        end
      end else begin
        chk("wb_idle_zero", 32'(|{wb_valid, wb_we, wb_rd, wb_wd, misalign, timeout_err}), 32'h0);
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_ready", ex_ready, 1'b0);
    chk_all_zero("rst_outputs");
    RST = 1'b0;
    #1;
    chk("ready_after_rst", ex_ready, 1'b1);
    mon_en = 1'b1;

    // Back-to-back non-memory beats.
    push_wb(5'd1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'd5, 5'd1);
    chk("t1_wbv0", wb_valid, 1'b1);
    push_wb(5'd2, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'd6, 5'd2);
    chk("t1_wbv1", wb_valid, 1'b1);
    push_wb(5'd0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'd7, 5'd0);
    chk("t1_wbv2", wb_valid, 1'b1);
    tick();

    // Ack while idle must be ignored.
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_no_req", dmem_req, 1'b0);

    // Stores.
    mem_txn(1'b1, 1'b0, F3Sb, 32'h103, 32'h0000_00AB, 5'd0, 3, 32'h0,
            4'b1000, 32'hABAB_ABAB, 32'h0);
    mem_txn(1'b1, 1'b1, F3Sh, 32'h302, 32'h0000_1234, 5'd9, 2, 32'hDEAD_BEEF,
            4'b1100, 32'h1234_1234, 32'h0);
    mem_txn(1'b1, 1'b0, F3Sw, 32'h304, 32'hCAFE_F00D, 5'd0, 1, 32'h0,
            4'b1111, 32'hCAFE_F00D, 32'h0);

    // Loads with extension.
    mem_txn(1'b0, 1'b0, F3Lb, 32'h200, 32'h0, 5'd3, 2, 32'h80F0_7F81,
            4'b0001, 32'h0, 32'hFFFF_FF81);
    mem_txn(1'b0, 1'b0, F3Lbu, 32'h200, 32'h0, 5'd4, 1, 32'h80F0_7F81,
            4'b0001, 32'h0, 32'h0000_0081);
    mem_txn(1'b0, 1'b0, F3Lh, 32'h202, 32'h0, 5'd5, 2, 32'h80F0_7F81,
            4'b1100, 32'h0, 32'hFFFF_80F0);
    mem_txn(1'b0, 1'b0, F3Lw, 32'h200, 32'h0, 5'd0, 3, 32'h80F0_7F81,
            4'b1111, 32'h0, 32'h80F0_7F81);
    mem_txn(1'b0, 1'b0, F3Lhu, 32'h202, 32'h0, 5'd8, 1, 32'h80F0_7F81,
            4'b1100, 32'h0, 32'h0000_80F0);

    // Misaligned accesses.
    mis_txn(F3Lw, 32'h102, 5'd10);
    mis_txn(F3Lh, 32'h101, 5'd11);

    // Timeout with no ack.
    issue(1'b0, 1'b1, 1'b1, F3Lw, 32'h400, 32'h0, 32'h0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", dmem_req, 1'b1);
      chk("tmo_not_ready", ex_ready, 1'b0);
      if (i == 3) push_wb(5'd6, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("tmo_req_drop", dmem_req, 1'b0);
    chk("tmo_ready", ex_ready, 1'b1);

    // Ack in the would-be timeout cycle retires normally.
    mem_txn(1'b0, 1'b0, F3Lw, 32'h400, 32'h0, 5'd6, 4, 32'h1234_5678,
            4'b1111, 32'h0, 32'h1234_5678);

    // Reset mid-transaction.
    issue(1'b0, 1'b1, 1'b1, F3Lw, 32'h500, 32'h0, 32'h0, 5'd7);
    tick();
    RST = 1'b1;
    #1;
    chk("rst_busy_ready", ex_ready, 1'b0);
    tick();
    chk_all_zero("rst_abort_outputs");
    RST = 1'b0;
    #1;
    chk("rst_abort_ready", ex_ready, 1'b1);
    mem_txn(1'b0, 1'b0, F3Lh, 32'h506, 32'h0, 5'd7, 2, 32'h7FFF_0000,
            4'b1100, 32'h0, 32'h0000_7FFF);

    tick();
    tick();
    chk("sb_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
